// File: rtl/bin_frame_packer_pkg.sv
// Package bin_pkg: shared types and constants for the bin frame packer.
//   DEFAULT_LANES / DEFAULT_W : default beat geometry (4 bins x 16 bits)
//   FRAME_MAGIC               : upper half of every frame header word
//   fifo_entry_t              : one buffered input beat {sof, last, seq, data}
//   wr_state_t / rd_state_t   : write-side and read-side FSM states
package bin_pkg;

    localparam int          DEFAULT_LANES = 4;
    localparam int          DEFAULT_W     = 16;
    localparam logic [15:0] FRAME_MAGIC   = 16'hA5A5;

    typedef struct packed {
        logic                                 sof;
        logic                                 last;
        logic [15:0]                          seq;
        logic [DEFAULT_LANES*DEFAULT_W-1:0]   data;
    } fifo_entry_t;

    typedef enum logic {
        WR_IDLE,
        WR_FRAME
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_HDR,
        RD_LO,
        RD_HI
    } rd_state_t;

endpackage

// File: rtl/bin_frame_packer_if.sv
// Output word stream of the bin frame packer (valid/ready with last).
//   m_tdata  : 32-bit output word
//   m_tvalid : word valid
//   m_tready : downstream ready
//   m_tlast  : last word of a frame
// master drives data/valid/last, slave drives ready.
interface bin_frame_packer_if;

    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;

    modport master (
        output m_tdata,
        output m_tvalid,
        output m_tlast,
        input  m_tready
    );

    modport slave (
        input  m_tdata,
        input  m_tvalid,
        input  m_tlast,
        output m_tready
    );

endinterface

// File: rtl/bin_frame_packer_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   wr_en      : write wr_data (ignored when full)
//   rd_en      : pop the head entry (ignored when empty)
//   rd_data    : head entry, valid whenever !empty
//   empty      : no entries stored
//   count      : number of stored entries (registered)
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    // Wrap explicitly so non-power-of-two depths also work.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
            if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/bin_frame_packer.sv
// bin_frame_packer: buffers averaged bin beats and emits them as framed
// 32-bit words: header {A5A5, seq}, then {lane1,lane0},{lane3,lane2} per beat,
// m_tlast on the final word. Frames that do not fit are dropped whole.
//   clk, rst_n     : clock, asynchronous active-low reset
//   in_data        : LANES x W bins, lane 0 in the low bits
//   in_valid       : beat qualifier (no backpressure)
//   in_sof         : first beat of a frame
//   m_axis         : output word stream (master side)
//   frames_dropped : saturating count of frames dropped for lack of space
//   sync_err       : sticky, in_sof seen in the middle of a frame
//   status_clr     : synchronous clear of frames_dropped and sync_err
module bin_frame_packer
    import bin_pkg::*;
#(
    parameter int LANES       = DEFAULT_LANES,
    parameter int W           = DEFAULT_W,
    parameter int FRAME_BEATS = 64,
    parameter int FIFO_DEPTH  = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [LANES-1:0][W-1:0] in_data,
    input  logic                    in_valid,
    input  logic                    in_sof,
    bin_frame_packer_if.master      m_axis,
    output logic [15:0]             frames_dropped,
    output logic                    sync_err,
    input  logic                    status_clr
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(FRAME_BEATS + 1);

    // Input stage
    logic                 r_valid;
    logic                 r_sof;
    logic [LANES*W-1:0]   r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_sof   <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= in_valid;
            r_sof   <= in_sof;
            r_data  <= in_data;
        end
    end

    // FIFO
    fifo_entry_t   wr_entry;
    fifo_entry_t   head;
    logic          fifo_wr;
    logic          fifo_rd;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    sync_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (fifo_wr),
        .wr_data (wr_entry),
        .rd_en   (fifo_rd),
        .rd_data (head),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Write side
    wr_state_t   wr_state, wr_next;
    logic [BW-1:0] beat_cnt, cnt_next;
    logic        discard, discard_next;
    logic [15:0] seq;
    logic        seq_inc;
    logic        drop_evt;
    logic        sync_evt;
    logic        room;
    logic        last_beat;

    // Registered count only: a pop in the same cycle is not credited.
    assign room      = (fifo_count <= CW'(FIFO_DEPTH - FRAME_BEATS));
    assign last_beat = (beat_cnt == BW'(FRAME_BEATS - 1));

    always_comb begin
        wr_next       = wr_state;
        cnt_next      = beat_cnt;
        discard_next  = discard;
        seq_inc       = 1'b0;
        drop_evt      = 1'b0;
        sync_evt      = 1'b0;
        fifo_wr       = 1'b0;
        wr_entry      = '0;
        wr_entry.data = r_data;

        case (wr_state)
            WR_IDLE: begin
                if (r_valid && r_sof) begin
                    seq_inc  = 1'b1;
                    cnt_next = BW'(1);
                    if (room) begin
                        fifo_wr       = 1'b1;
                        wr_entry.sof  = 1'b1;
                        wr_entry.last = (FRAME_BEATS == 1);
                        wr_entry.seq  = seq;
                        discard_next  = 1'b0;
                    end else begin
                        drop_evt      = 1'b1;
                        discard_next  = 1'b1;
                    end
                    wr_next = (FRAME_BEATS == 1) ? WR_IDLE : WR_FRAME;
                end
            end
            WR_FRAME: begin
                if (r_valid) begin
                    sync_evt      = r_sof;
                    fifo_wr       = !discard;
                    wr_entry.last = last_beat;
                    cnt_next      = beat_cnt + BW'(1);
                    if (last_beat) wr_next = WR_IDLE;
                end
            end
            default: wr_next = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state <= WR_IDLE;
            beat_cnt <= '0;
            discard  <= 1'b0;
            seq      <= '0;
        end else begin
            wr_state <= wr_next;
            beat_cnt <= cnt_next;
            discard  <= discard_next;
            if (seq_inc) seq <= seq + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_dropped <= '0;
            sync_err       <= 1'b0;
        end else if (status_clr) begin
            frames_dropped <= '0;
            sync_err       <= 1'b0;
        end else begin
            if (drop_evt && (frames_dropped != 16'hFFFF))
                frames_dropped <= frames_dropped + 16'd1;
            if (sync_evt) sync_err <= 1'b1;
        end
    end

    // Read side
    rd_state_t rd_state, rd_next;

    always_comb begin
        rd_next         = rd_state;
        fifo_rd         = 1'b0;
        m_axis.m_tvalid = 1'b0;
        m_axis.m_tdata  = '0;
        m_axis.m_tlast  = 1'b0;

        case (rd_state)
            RD_IDLE: begin
                // A head without sof cannot be the start of a frame; discard it.
                if (!fifo_empty) begin
                    if (head.sof) rd_next = RD_HDR;
                    else          fifo_rd = 1'b1;
                end
            end
            RD_HDR: begin
                m_axis.m_tvalid = 1'b1;
                m_axis.m_tdata  = {FRAME_MAGIC, head.seq};
                if (m_axis.m_tready) rd_next = RD_LO;
            end
            RD_LO: begin
                // Later beats of an admitted frame may still be in flight.
                m_axis.m_tvalid = !fifo_empty;
                m_axis.m_tdata  = head.data[31:0];
                if (!fifo_empty && m_axis.m_tready) rd_next = RD_HI;
            end
            RD_HI: begin
                m_axis.m_tvalid = 1'b1;
                m_axis.m_tdata  = head.data[63:32];
                m_axis.m_tlast  = head.last;
                if (m_axis.m_tready) begin
                    fifo_rd = 1'b1;
                    rd_next = head.last ? RD_IDLE : RD_LO;
                end
            end
            default: rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_state <= RD_IDLE;
        else        rd_state <= rd_next;
    end

endmodule

// File: tb/tb_bin_frame_packer.sv
// Directed testbench for bin_frame_packer with FRAME_BEATS=4, FIFO_DEPTH=8.
module tb_bin_frame_packer;

    localparam int FB    = 4;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0][15:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_sof = 1'b0;
    logic [15:0]      frames_dropped;
    logic             sync_err;
    logic             status_clr = 1'b0;

    bin_frame_packer_if axis();

    bin_frame_packer #(
        .LANES       (4),
        .W           (16),
        .FRAME_BEATS (FB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_sof         (in_sof),
        .m_axis         (axis),
        .frames_dropped (frames_dropped),
        .sync_err       (sync_err),
        .status_clr     (status_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Received words
    logic [31:0] rx_data[$];
    logic        rx_last[$];
    int          rx_cyc[$];
    int          sof_cyc = 0;

    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    always @(negedge clk) begin
        #3;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(axis.m_tvalid), 32'd1);
                check("hold_data", axis.m_tdata, prev_data);
                check("hold_last", 32'(axis.m_tlast), 32'(prev_last));
            end
            if (axis.m_tvalid && axis.m_tready) begin
                rx_data.push_back(axis.m_tdata);
                rx_last.push_back(axis.m_tlast);
                rx_cyc.push_back(cyc);
            end
            prev_stall = axis.m_tvalid && !axis.m_tready;
            prev_data  = axis.m_tdata;
            prev_last  = axis.m_tlast;
        end
    end

    // Expected word i of a frame whose beat b carries lane k = base + 4b + k.
    function automatic logic [31:0] exp_word(input logic [15:0] seq, input logic [15:0] base, input int i);
        int          b;
        logic [15:0] l0;
        if (i == 0) return {16'hA5A5, seq};
        b  = (i - 1) / 2;
        l0 = base + 16'(4 * b);
        return (((i - 1) % 2) == 0) ? {l0 + 16'd1, l0} : {l0 + 16'd3, l0 + 16'd2};
    endfunction

    task automatic check_frame(input string tag, input logic [15:0] seq, input logic [15:0] base, input int start);
        logic [31:0] gd;
        logic        gl;
        for (int i = 0; i < 2 * FB + 1; i++) begin
            gd = (start + i < rx_data.size()) ? rx_data[start + i] : 32'hxxxx_xxxx;
            gl = (start + i < rx_last.size()) ? rx_last[start + i] : 1'bx;
            check($sformatf("%s_w%0d", tag, i), gd, exp_word(seq, base, i));
            check($sformatf("%s_last%0d", tag, i), 32'(gl), 32'(i == 2 * FB));
        end
    endtask

    task automatic wait_words(input int n, input int budget);
        int t = 0;
        while (rx_data.size() < n && t < budget) begin
            @(negedge clk);
            #4;
            t++;
        end
        check("word_count", 32'(rx_data.size()), 32'(n));
    endtask

    task automatic send_frame(input logic [15:0] base, input int sof2);
        for (int b = 0; b < FB; b++) begin
            @(negedge clk);
            if (b == 0) sof_cyc = cyc;
            in_valid = 1'b1;
            in_sof   = (b == 0) || (b == sof2);
            for (int k = 0; k < 4; k++) in_data[k] = base + 16'(4 * b + k);
        end
    endtask

    task automatic idle_in();
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        axis.m_tready = 1'b0;

        // Reset values
        #12;
        check("rst_tvalid", 32'(axis.m_tvalid), 32'd0);
        check("rst_tlast", 32'(axis.m_tlast), 32'd0);
        check("rst_tdata", axis.m_tdata, 32'd0);
        check("rst_dropped", 32'(frames_dropped), 32'd0);
        check("rst_sync_err", 32'(sync_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single frame, ready always high
        axis.m_tready = 1'b1;
        send_frame(16'h0000, -1);
        idle_in();
        wait_words(9, 50);
        check("latency", 32'((rx_cyc.size() > 0) ? rx_cyc[0] - sof_cyc : -1), 32'd3);
        check("burst_len", 32'((rx_cyc.size() > 8) ? rx_cyc[8] - rx_cyc[0] : -1), 32'd8);
        check_frame("single", 16'd0, 16'h0000, 0);

        // Random backpressure
        rx_data.delete(); rx_last.delete(); rx_cyc.delete();
        fork
            begin
                send_frame(16'h0100, -1);
                idle_in();
            end
            begin
                for (int i = 0; i < 300; i++) begin
                    if (rx_data.size() >= 9) break;
                    @(negedge clk);
                    axis.m_tready = 1'($urandom_range(0, 1));
                end
            end
        join
        axis.m_tready = 1'b1;
        wait_words(9, 50);
        check_frame("bp", 16'd1, 16'h0100, 0);

        // Overflow: three back-to-back frames into an 8-entry FIFO, no ready
        do_reset();
        rx_data.delete(); rx_last.delete(); rx_cyc.delete();
        axis.m_tready = 1'b0;
        send_frame(16'h1000, -1);
        send_frame(16'h2000, -1);
        send_frame(16'h3000, -1);
        idle_in();
        repeat (4) @(negedge clk);
        check("ovf_dropped", 32'(frames_dropped), 32'd1);
        axis.m_tready = 1'b1;
        wait_words(18, 100);
        check_frame("ovf0", 16'd0, 16'h1000, 0);
        check_frame("ovf1", 16'd1, 16'h2000, 9);
        repeat (6) @(negedge clk);
        check("ovf_total", 32'(rx_data.size()), 32'd18);
        rx_data.delete(); rx_last.delete(); rx_cyc.delete();
        send_frame(16'h4000, -1);
        idle_in();
        wait_words(9, 50);
        check_frame("ovf_next", 16'd3, 16'h4000, 0);

        // Sync error: extra sof on beat 2
        rx_data.delete(); rx_last.delete(); rx_cyc.delete();
        send_frame(16'h5000, 2);
        idle_in();
        wait_words(9, 50);
        check("sync_err_set", 32'(sync_err), 32'd1);
        check_frame("sync", 16'd4, 16'h5000, 0);

        // Stray beats without sof produce nothing
        rx_data.delete(); rx_last.delete(); rx_cyc.delete();
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_sof   = 1'b0;
            for (int k = 0; k < 4; k++) in_data[k] = 16'hEE00 + 16'(4 * b + k);
        end
        idle_in();
        repeat (8) @(negedge clk);
        check("stray_words", 32'(rx_data.size()), 32'd0);
        check("pre_clr_dropped", 32'(frames_dropped), 32'd1);
        check("pre_clr_sync", 32'(sync_err), 32'd1);
        @(negedge clk);
        status_clr = 1'b1;
        @(negedge clk);
        status_clr = 1'b0;
        check("clr_dropped", 32'(frames_dropped), 32'd0);
        check("clr_sync", 32'(sync_err), 32'd0);
        send_frame(16'h6000, -1);
        idle_in();
        wait_words(9, 50);
        check_frame("post_clr", 16'd5, 16'h6000, 0);

        // Reset while word 5 is on the bus
        rx_data.delete(); rx_last.delete(); rx_cyc.delete();
        send_frame(16'h7000, -1);
        idle_in();
        wait_words(4, 50);
        @(posedge clk);
        #2;
        check("pre_rst_valid", 32'(axis.m_tvalid), 32'd1);
        check("pre_rst_word5", axis.m_tdata, exp_word(16'd6, 16'h7000, 4));
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", 32'(axis.m_tvalid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rx_data.delete(); rx_last.delete(); rx_cyc.delete();
        repeat (4) @(negedge clk);
        check("post_rst_idle", 32'(rx_data.size()), 32'd0);
        send_frame(16'h8000, -1);
        idle_in();
        wait_words(9, 50);
        check_frame("post_rst", 16'd0, 16'h8000, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
